write_operation: RTL and testbench

- Write-side register block of FactoCore; the counterpart of the register read mux.
- Accepts single-cycle bus writes, decodes the 8-bit address and holds the writable control registers (opstart, opclear, intrEn, operand).
- Generates one-cycle start/clear strobes for the factorial FSM and write acknowledge/error status.
- Register outputs feed the read mux slots 0, 1, 3 and 4. Slots 2, 5 and 6 are owned by the core datapath.

---
 rtl/write_operation.sv | 141 ++++++++++++++
 tb/tb_write_operation.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/write_operation.sv
// write_operation: write-side register block of FactoCore.
// Decodes single-cycle bus writes into the writable control registers and
// produces one-cycle start/clear strobes for the factorial FSM, plus a write
// acknowledge and a sticky write-error flag. Every output is registered, so
// there is no combinational path from the bus inputs to any output.
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   S_sel       slave select
//   S_wr        write request (accepted when S_sel & S_wr at a rising edge)
//   S_addr      byte address of the write
//   S_din       write data
//   busy        factorial FSM is computing
//   opstart_q   opstart register (bit0 only)
//   opclear_q   opclear register (bit0 only, high for one cycle)
//   intrEn_q    interrupt enable register (bit0 only)
//   operand_q   operand register
//   start_pulse one-cycle start strobe
//   clear_pulse one-cycle clear strobe
//   wr_ack      one-cycle acknowledge per accepted write
//   wr_err      sticky error flag
module write_operation #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  S_sel,
  input  logic                  S_wr,
  input  logic [ADDR_WIDTH-1:0] S_addr,
  input  logic [DATA_WIDTH-1:0] S_din,
  input  logic                  busy,
  output logic [DATA_WIDTH-1:0] opstart_q,
  output logic [DATA_WIDTH-1:0] opclear_q,
  output logic [DATA_WIDTH-1:0] intrEn_q,
  output logic [DATA_WIDTH-1:0] operand_q,
  output logic                  start_pulse,
  output logic                  clear_pulse,
  output logic                  wr_ack,
  output logic                  wr_err
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_OPSTART = ADDR_WIDTH'('h00);
  localparam logic [ADDR_WIDTH-1:0] ADDR_OPCLEAR = ADDR_WIDTH'('h08);
  localparam logic [ADDR_WIDTH-1:0] ADDR_INTREN  = ADDR_WIDTH'('h18);
  localparam logic [ADDR_WIDTH-1:0] ADDR_OPERAND = ADDR_WIDTH'('h20);

  logic                  opstart_bit_q, opstart_bit_d;
  logic                  opclear_bit_q, opclear_bit_d;
  logic                  intren_bit_q,  intren_bit_d;
  logic [DATA_WIDTH-1:0] operand_reg_q, operand_reg_d;
  logic                  start_q, start_d;
  logic                  clear_q, clear_d;
  logic                  ack_q,   ack_d;
  logic                  err_q,   err_d;
  logic                  wr_en;

  assign wr_en = S_sel & S_wr;

  always_comb begin
    opstart_bit_d = opstart_bit_q;
    opclear_bit_d = 1'b0;            // opclear self-clears after one cycle
    intren_bit_d  = intren_bit_q;
    operand_reg_d = operand_reg_q;
    start_d       = 1'b0;
    clear_d       = 1'b0;
    ack_d         = wr_en;           // ack every accepted write, even erroring ones
    err_d         = err_q;
    if (wr_en) begin
      unique case (S_addr)
        ADDR_OPSTART: begin
          if (!S_din[0]) begin
            opstart_bit_d = 1'b0;    // stopping is always allowed
          end else if (busy) begin
            err_d = 1'b1;
          end else begin
            opstart_bit_d = 1'b1;
            start_d       = 1'b1;    // re-issued even if opstart already set
          end
        end
        ADDR_OPCLEAR: begin
          // Clear dominates busy; intrEn survives a clear.
          if (S_din[0]) begin
            opclear_bit_d = 1'b1;
            clear_d       = 1'b1;
            opstart_bit_d = 1'b0;
            operand_reg_d = '0;
            err_d         = 1'b0;
          end
        end
        ADDR_INTREN: begin
          intren_bit_d = S_din[0];
        end
        ADDR_OPERAND: begin
          if (busy) begin
            err_d = 1'b1;
          end else begin
            operand_reg_d = S_din;
          end
        end
        default: begin
          // Read-only (opdone, result_h, result_l) or unmapped.
          err_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opstart_bit_q <= 1'b0;
      opclear_bit_q <= 1'b0;
      intren_bit_q  <= 1'b0;
      operand_reg_q <= '0;
      start_q       <= 1'b0;
      clear_q       <= 1'b0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      opstart_bit_q <= opstart_bit_d;
      opclear_bit_q <= opclear_bit_d;
      intren_bit_q  <= intren_bit_d;
      operand_reg_q <= operand_reg_d;
      start_q       <= start_d;
      clear_q       <= clear_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
    end
  end

  assign opstart_q   = {{(DATA_WIDTH-1){1'b0}}, opstart_bit_q};
  assign opclear_q   = {{(DATA_WIDTH-1){1'b0}}, opclear_bit_q};
  assign intrEn_q    = {{(DATA_WIDTH-1){1'b0}}, intren_bit_q};
  assign operand_q   = operand_reg_q;
  assign start_pulse = start_q;
  assign clear_pulse = clear_q;
  assign wr_ack      = ack_q;
  assign wr_err      = err_q;

endmodule

// File: tb/tb_write_operation.sv
// Directed testbench for write_operation.
module tb_write_operation;

  logic        clk;
  logic        reset_n;
  logic        S_sel;
  logic        S_wr;
  logic [7:0]  S_addr;
  logic [63:0] S_din;
  logic        busy;
  logic [63:0] opstart_q;
  logic [63:0] opclear_q;
  logic [63:0] intrEn_q;
  logic [63:0] operand_q;
  logic        start_pulse;
  logic        clear_pulse;
  logic        wr_ack;
  logic        wr_err;

  int tests = 0;
  int fails = 0;

  write_operation #(.DATA_WIDTH(64), .ADDR_WIDTH(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .S_sel       (S_sel),
    .S_wr        (S_wr),
    .S_addr      (S_addr),
    .S_din       (S_din),
    .busy        (busy),
    .opstart_q   (opstart_q),
    .opclear_q   (opclear_q),
    .intrEn_q    (intrEn_q),
    .operand_q   (operand_q),
    .start_pulse (start_pulse),
    .clear_pulse (clear_pulse),
    .wr_ack      (wr_ack),
    .wr_err      (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a write on the bus, then sample 1 time unit after the accepting edge.
  task automatic bus_write(input logic [7:0] a, input logic [63:0] d);
    @(negedge clk);
    S_sel  = 1'b1;
    S_wr   = 1'b1;
    S_addr = a;
    S_din  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    S_sel = 1'b0;
    S_wr  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    busy    = 1'b0;
    S_sel   = 1'b1;
    S_wr    = 1'b1;
    S_addr  = 8'h00;
    S_din   = 64'd1;

    // Reset held with a write presented on the bus.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_opstart", opstart_q, 64'd0);
    chk("rst_start",   {63'd0, start_pulse}, 64'd0);
    chk("rst_ack",     {63'd0, wr_ack}, 64'd0);
    chk("rst_err",     {63'd0, wr_err}, 64'd0);
    chk("rst_operand", operand_q, 64'd0);
    chk("rst_intr",    intrEn_q, 64'd0);

    @(negedge clk);
    S_sel = 1'b0;
    S_wr  = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ack",     {63'd0, wr_ack}, 64'd0);
    chk("post_rst_opstart", opstart_q, 64'd0);

    // Operand then start, busy low.
    bus_write(8'h20, 64'h0000_0000_0000_0005);
    chk("op_wr_operand", operand_q, 64'd5);
    chk("op_wr_ack",     {63'd0, wr_ack}, 64'd1);
    chk("op_wr_start",   {63'd0, start_pulse}, 64'd0);
    bus_write(8'h00, 64'd1);
    chk("start_pulse",   {63'd0, start_pulse}, 64'd1);
    chk("start_opstart", opstart_q, 64'd1);
    chk("start_ack",     {63'd0, wr_ack}, 64'd1);
    chk("start_err",     {63'd0, wr_err}, 64'd0);
    bus_idle();
    chk("start_pulse_drop", {63'd0, start_pulse}, 64'd0);
    chk("start_hold",       opstart_q, 64'd1);
    chk("idle_ack",         {63'd0, wr_ack}, 64'd0);

    // Re-start while opstart already 1 issues another pulse.
    bus_write(8'h00, 64'd1);
    chk("restart_pulse", {63'd0, start_pulse}, 64'd1);
    bus_idle();

    // Busy: operand and start writes rejected.
    busy = 1'b1;
    bus_write(8'h20, 64'd9);
    chk("busy_operand", operand_q, 64'd5);
    chk("busy_err1",    {63'd0, wr_err}, 64'd1);
    chk("busy_ack1",    {63'd0, wr_ack}, 64'd1);
    bus_write(8'h00, 64'd1);
    chk("busy_start",   {63'd0, start_pulse}, 64'd0);
    chk("busy_ack2",    {63'd0, wr_ack}, 64'd1);
    chk("busy_err2",    {63'd0, wr_err}, 64'd1);
    chk("busy_opstart", opstart_q, 64'd1);
    bus_idle();

    // intrEn writable while busy; clear dominates busy.
    bus_write(8'h18, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("intr_set", intrEn_q, 64'd1);
    bus_write(8'h08, 64'd1);
    chk("clr_pulse",   {63'd0, clear_pulse}, 64'd1);
    chk("clr_opclear", opclear_q, 64'd1);
    chk("clr_opstart", opstart_q, 64'd0);
    chk("clr_operand", operand_q, 64'd0);
    chk("clr_err",     {63'd0, wr_err}, 64'd0);
    chk("clr_intr",    intrEn_q, 64'd1);
    chk("clr_nostart", {63'd0, start_pulse}, 64'd0);
    bus_idle();
    chk("clr_pulse_drop",   {63'd0, clear_pulse}, 64'd0);
    chk("clr_opclear_drop", opclear_q, 64'd0);

    // opclear with bit0=0 only acknowledges.
    busy = 1'b0;
    bus_write(8'h08, 64'd0);
    chk("clr0_ack",   {63'd0, wr_ack}, 64'd1);
    chk("clr0_pulse", {63'd0, clear_pulse}, 64'd0);
    chk("clr0_reg",   opclear_q, 64'd0);

    // Read-only and unmapped writes.
    bus_write(8'h28, 64'hFFFF);
    chk("ro_err",     {63'd0, wr_err}, 64'd1);
    chk("ro_ack",     {63'd0, wr_ack}, 64'd1);
    chk("ro_operand", operand_q, 64'd0);
    bus_write(8'h40, 64'd1);
    chk("unmap_ack",     {63'd0, wr_ack}, 64'd1);
    chk("unmap_opstart", opstart_q, 64'd0);

    // S_wr without S_sel is ignored.
    @(negedge clk);
    S_sel  = 1'b0;
    S_wr   = 1'b1;
    S_addr = 8'h00;
    S_din  = 64'd1;
    @(posedge clk);
    #1;
    chk("nosel_ack",   {63'd0, wr_ack}, 64'd0);
    chk("nosel_start", {63'd0, start_pulse}, 64'd0);
    chk("nosel_err",   {63'd0, wr_err}, 64'd1);

    // Stopping opstart is allowed while busy and does not touch wr_err.
    bus_write(8'h00, 64'd1);
    chk("set_again", opstart_q, 64'd1);
    busy = 1'b1;
    bus_write(8'h00, 64'd0);
    chk("stop_busy",     opstart_q, 64'd0);
    chk("stop_busy_err", {63'd0, wr_err}, 64'd1);
    busy = 1'b0;

    // Async reset in the cycle a start pulse is showing.
    bus_write(8'h00, 64'd1);
    chk("pre_rst_pulse", {63'd0, start_pulse}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_start",   {63'd0, start_pulse}, 64'd0);
    chk("arst_opstart", opstart_q, 64'd0);
    chk("arst_err",     {63'd0, wr_err}, 64'd0);
    chk("arst_ack",     {63'd0, wr_ack}, 64'd0);
    chk("arst_intr",    intrEn_q, 64'd0);
    @(negedge clk);
    S_sel = 1'b0;
    S_wr  = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_after", {63'd0, start_pulse}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
